issue_pair_select: RTL and testbench

- ID-stage issue-pairing unit, directly downstream of the instruction queue.
- Each cycle it inspects the two head instructions the queue presents and decides whether to issue 2, 1 or 0 of them.
- It returns the dequeue count to the queue as ID_upDateMode_o and latches the issued slots into the ID/IS pipeline register, handshaking with the issue stage.
- It enforces MIPS branch/delay-slot pairing and intra-pair hazards.

---
 rtl/issue_pair_select_if.sv | 62 ++++++
 rtl/issue_pair_select.sv | 173 +++++++++++++++++
 tb/tb_issue_pair_select.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_pair_select_if.sv
// Bundle between the instruction queue / issue stage and issue_pair_select.
// The slave modport is the pairing unit's view; master is the surrounding
// pipeline (queue head, flush sources, issue stage).
// Optional ID_PAIR_PERF_EN adds the three 32-bit performance counters.
interface issue_pair_select_if #(
  parameter int CKPT_W = 8,
  parameter int EXC_W  = 5
);
  logic                  SBA_flush_w_i;
  logic                  CP0_excOccur_w_i;
  logic [1:0]            IQ_supplyValid_i;
  logic [63:0]           IQ_inst_p_i;
  logic [63:0]           IQ_VAddr_p_i;
  logic [1:0]            IQ_hasException_p_i;
  logic [2*EXC_W-1:0]    IQ_ExcCode_p_i;
  logic [1:0]            IQ_isRefill_p_i;
  logic [63:0]           IQ_predDest_p_i;
  logic [1:0]            IQ_predTake_p_i;
  logic [2*CKPT_W-1:0]   IQ_checkPoint_p_i;
  logic                  IS_ready_i;

  logic [1:0]            ID_upDateMode_o;
  logic [1:0]            ID_valid_o;
  logic [63:0]           ID_inst_p_o;
  logic [63:0]           ID_VAddr_p_o;
  logic [1:0]            ID_hasException_p_o;
  logic [2*EXC_W-1:0]    ID_ExcCode_p_o;
  logic [1:0]            ID_isRefill_p_o;
  logic [63:0]           ID_predDest_p_o;
  logic [1:0]            ID_predTake_p_o;
  logic [2*CKPT_W-1:0]   ID_checkPoint_p_o;
  logic [1:0]            ID_isBranch_p_o;
`ifdef ID_PAIR_PERF_EN
  logic [31:0]           ID_dualCnt_o;
  logic [31:0]           ID_singleCnt_o;
  logic [31:0]           ID_stallCnt_o;
`endif

  modport slave (
    input  SBA_flush_w_i, CP0_excOccur_w_i, IQ_supplyValid_i, IQ_inst_p_i,
           IQ_VAddr_p_i, IQ_hasException_p_i, IQ_ExcCode_p_i, IQ_isRefill_p_i,
           IQ_predDest_p_i, IQ_predTake_p_i, IQ_checkPoint_p_i, IS_ready_i,
    output ID_upDateMode_o, ID_valid_o, ID_inst_p_o, ID_VAddr_p_o,
           ID_hasException_p_o, ID_ExcCode_p_o, ID_isRefill_p_o,
           ID_predDest_p_o, ID_predTake_p_o, ID_checkPoint_p_o, ID_isBranch_p_o
`ifdef ID_PAIR_PERF_EN
    , output ID_dualCnt_o, ID_singleCnt_o, ID_stallCnt_o
`endif
  );

  modport master (
    output SBA_flush_w_i, CP0_excOccur_w_i, IQ_supplyValid_i, IQ_inst_p_i,
           IQ_VAddr_p_i, IQ_hasException_p_i, IQ_ExcCode_p_i, IQ_isRefill_p_i,
           IQ_predDest_p_i, IQ_predTake_p_i, IQ_checkPoint_p_i, IS_ready_i,
    input  ID_upDateMode_o, ID_valid_o, ID_inst_p_o, ID_VAddr_p_o,
           ID_hasException_p_o, ID_ExcCode_p_o, ID_isRefill_p_o,
           ID_predDest_p_o, ID_predTake_p_o, ID_checkPoint_p_o, ID_isBranch_p_o
`ifdef ID_PAIR_PERF_EN
    , input ID_dualCnt_o, ID_singleCnt_o, ID_stallCnt_o
`endif
  );
endinterface

// File: rtl/issue_pair_select.sv
// ID-stage issue pairing: decides how many of the two queue-head instructions
// issue this cycle (0/1/2), returns that as the dequeue count and latches the
// pair into the ID/IS register. Keeps a branch together with its delay slot.
// Optional ID_PAIR_PERF_EN adds dual/single/stall issue counters.
module issue_pair_select #(
  parameter int CKPT_W = 8,
  parameter int EXC_W  = 5
) (
  input logic clk,
  input logic rst,
  issue_pair_select_if.slave bus
);

  typedef enum logic {NORMAL = 1'b0, WAIT_DS = 1'b1} state_t;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_ONE  = 2'b01;
  localparam logic [1:0] MODE_TWO  = 2'b11;

  typedef struct packed {
    logic       br;
    logic       mem;
    logic       priv;
    logic [4:0] dest;    // 0 means no destination
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] fn;
    op       = inst[31:26];
    fn       = inst[5:0];
    d        = '0;
    d.rs     = inst[25:21];
    d.rt     = inst[20:16];
    d.br     = (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) || op == 6'h01 ||
               (op >= 6'h02 && op <= 6'h07) || (op >= 6'h14 && op <= 6'h17);
    d.mem    = op >= 6'h20 && op <= 6'h2B;
    d.priv   = op == 6'h10 || (op == 6'h00 && (fn == 6'h0C || fn == 6'h0D));
    if (op == 6'h00)
      d.dest = inst[15:11];
    else if ((op >= 6'h08 && op <= 6'h0F) || (op >= 6'h20 && op <= 6'h25))
      d.dest = inst[20:16];
    else if (op == 6'h03 || (op == 6'h01 && (inst[20:16] == 5'h10 || inst[20:16] == 5'h11)))
      d.dest = 5'd31;
    d.use_rt = op == 6'h00 || op == 6'h04 || op == 6'h05 || (op >= 6'h28 && op <= 6'h2B);
    return d;
  endfunction

  state_t     state;
  state_t     state_nxt;
  logic [1:0] mode;
  dec_t       dec0;
  dec_t       dec1;
  logic       flush;
  logic       adv;
  logic       go;
  logic       supply_any;
  logic       supply_two;
  logic       raw_hazard;
  logic       single_only;

  assign dec0       = decode(bus.IQ_inst_p_i[31:0]);
  assign dec1       = decode(bus.IQ_inst_p_i[63:32]);
  assign flush      = bus.SBA_flush_w_i | bus.CP0_excOccur_w_i;
  // 2'b10 is not a legal queue head and is read as empty
  assign supply_any = bus.IQ_supplyValid_i[0];
  assign supply_two = bus.IQ_supplyValid_i == 2'b11;
  assign adv        = (bus.ID_valid_o == 2'b00) | bus.IS_ready_i;
  assign go         = adv & ~flush & ~rst;

  assign raw_hazard  = (dec0.dest != 5'd0) &&
                       (dec1.rs == dec0.dest || (dec1.use_rt && dec1.rt == dec0.dest));
  assign single_only = dec1.br | (|bus.IQ_hasException_p_i) | dec0.priv | dec1.priv |
                       (dec0.mem & dec1.mem) | raw_hazard;

  // State register: flush and reset both return to NORMAL
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst || flush) state <= NORMAL;
    else              state <= state_nxt;
  end

  // Next state: enter WAIT_DS on a lone branch, leave once its slot arrives
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    if (go) begin
      case (state)
        NORMAL:  if (supply_any && dec0.br && !supply_two) state_nxt = WAIT_DS;
        WAIT_DS: if ((supply_any && bus.IQ_hasException_p_i[0]) || supply_two)
                   state_nxt = NORMAL;
        default: state_nxt = NORMAL;
      endcase
    end
  end

  // Output decode: dequeue count for the queue head
  always_comb begin
    mode = MODE_NONE;
    if (go) begin
      case (state)
        NORMAL: begin
          if (supply_any) begin
            if (dec0.br)          mode = supply_two ? MODE_TWO : MODE_NONE;
            else if (!supply_two) mode = MODE_ONE;
            else                  mode = single_only ? MODE_ONE : MODE_TWO;
          end
        end
        WAIT_DS: begin
          // A faulting branch goes alone; the exception outranks pairing
          if (supply_any && bus.IQ_hasException_p_i[0]) mode = MODE_ONE;
          else if (supply_two)                          mode = MODE_TWO;
        end
        default: mode = MODE_NONE;
      endcase
    end
  end

  assign bus.ID_upDateMode_o = mode;

  // ID/IS register: load both slots on advance, kill validity on flush
  always_ff @(posedge clk) begin
    // NOTE: the payload is reset too so downstream sees zeros, not X, after
    // reset; it is a handful of flops, not a memory array.
    if (rst) begin
      bus.ID_valid_o          <= 2'b00;
      bus.ID_inst_p_o         <= '0;
      bus.ID_VAddr_p_o        <= '0;
      bus.ID_hasException_p_o <= '0;
      bus.ID_ExcCode_p_o      <= '0;
      bus.ID_isRefill_p_o     <= '0;
      bus.ID_predDest_p_o     <= '0;
      bus.ID_predTake_p_o     <= '0;
      bus.ID_checkPoint_p_o   <= '0;
      bus.ID_isBranch_p_o     <= 2'b00;
    end else if (flush) begin
      bus.ID_valid_o <= 2'b00;
    end else if (adv) begin
      bus.ID_valid_o          <= mode;
      bus.ID_inst_p_o         <= bus.IQ_inst_p_i;
      bus.ID_VAddr_p_o        <= bus.IQ_VAddr_p_i;
      bus.ID_hasException_p_o <= bus.IQ_hasException_p_i;
      bus.ID_ExcCode_p_o      <= bus.IQ_ExcCode_p_i;
      bus.ID_isRefill_p_o     <= bus.IQ_isRefill_p_i;
      bus.ID_predDest_p_o     <= bus.IQ_predDest_p_i;
      bus.ID_predTake_p_o     <= bus.IQ_predTake_p_i;
      bus.ID_checkPoint_p_o   <= bus.IQ_checkPoint_p_i;
      bus.ID_isBranch_p_o     <= {dec1.br, dec0.br};
    end
  end

`ifdef ID_PAIR_PERF_EN
  // Performance counters: free-running, wrap at 2^32, ignore flush
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ID_dualCnt_o   <= '0;
      bus.ID_singleCnt_o <= '0;
      bus.ID_stallCnt_o  <= '0;
    end else begin
      if (mode == MODE_TWO)                bus.ID_dualCnt_o   <= bus.ID_dualCnt_o + 32'd1;
      if (mode == MODE_ONE)                bus.ID_singleCnt_o <= bus.ID_singleCnt_o + 32'd1;
      if (supply_any && mode == MODE_NONE) bus.ID_stallCnt_o  <= bus.ID_stallCnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_pair_select.sv
// Scoreboard bench for issue_pair_select: directed scenarios then random
// traffic. The driver predicts each cycle's dequeue count and each latched
// pair from the pairing rules; a negedge monitor compares them.
// Honours ID_PAIR_PERF_EN when compiled with it.
module tb_issue_pair_select;
  localparam int CKPT_W = 8;
  localparam int EXC_W  = 5;

  typedef struct packed {
    logic [1:0]          valid;
    logic [63:0]         inst;
    logic [63:0]         vaddr;
    logic [1:0]          hexc;
    logic [2*EXC_W-1:0]  ecode;
    logic [1:0]          refill;
    logic [63:0]         pdest;
    logic [1:0]          ptake;
    logic [2*CKPT_W-1:0] ckpt;
    logic [1:0]          isbr;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] mode_q[$];
  entry_t     exp_q[$];
  logic [1:0] m_valid = 2'b00;
  logic       m_wait = 1'b0;
  int unsigned n_dual = 0, n_single = 0, n_stall = 0;

  issue_pair_select_if #(.CKPT_W(CKPT_W), .EXC_W(EXC_W)) bus ();

  issue_pair_select #(.CKPT_W(CKPT_W), .EXC_W(EXC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference rules, stated per instruction class
  function automatic logic m_br(input logic [31:0] i);
    return (i[31:26] == 6'h00 && i[5:0] inside {6'h08, 6'h09}) ||
           i[31:26] inside {6'h01, [6'h02:6'h07], [6'h14:6'h17]};
  endfunction
  function automatic logic m_mem(input logic [31:0] i);
    return i[31:26] inside {[6'h20:6'h2B]};
  endfunction
  function automatic logic m_priv(input logic [31:0] i);
    return i[31:26] == 6'h10 || (i[31:26] == 6'h00 && i[5:0] inside {6'h0C, 6'h0D});
  endfunction
  function automatic logic [4:0] m_dest(input logic [31:0] i);
    if (i[31:26] == 6'h00) return i[15:11];
    if (i[31:26] inside {[6'h08:6'h0F], [6'h20:6'h25]}) return i[20:16];
    if (i[31:26] == 6'h03) return 5'd31;
    if (i[31:26] == 6'h01 && i[20:16] inside {5'h10, 5'h11}) return 5'd31;
    return 5'd0;
  endfunction
  function automatic logic m_reads(input logic [31:0] i, input logic [4:0] r);
    logic rt_used;
    rt_used = i[31:26] inside {6'h00, 6'h04, 6'h05, [6'h28:6'h2B]};
    return i[25:21] == r || (rt_used && i[20:16] == r);
  endfunction
  function automatic logic m_single(input logic [31:0] i0, input logic [31:0] i1,
                                    input logic [1:0] exc);
    logic [4:0] d;
    d = m_dest(i0);
    return m_br(i1) || exc != 2'b00 || m_priv(i0) || m_priv(i1) ||
           (m_mem(i0) && m_mem(i1)) || (d != 5'd0 && m_reads(i1, d));
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt);
    return {op, rs, rt, 16'h0010};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0] rs, rt, rd;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 13))
      0:  return r_type(rs, rt, rd, 6'h21);          // ADDU
      1:  return r_type(rs, rt, rd, 6'h23);          // SUBU
      2:  return i_type(6'h23, rs, rt);              // LW
      3:  return i_type(6'h2B, rs, rt);              // SW
      4:  return i_type(6'h04, rs, rt);              // BEQ
      5:  return i_type(6'h05, rs, rt);              // BNE
      6:  return {6'h02, 26'h0000100};               // J
      7:  return {6'h03, 26'h0000200};               // JAL
      8:  return r_type(rs, 5'd0, 5'd0, 6'h08);      // JR
      9:  return i_type(6'h09, rs, rt);              // ADDIU
      10: return {6'h00, 20'd0, 6'h0C};              // SYSCALL
      11: return {6'h10, 5'd0, rt, rd, 11'd0};       // MFC0
      12: return {6'h01, rs, 5'h10, 16'h0004};       // BLTZAL
      default: return {6'h0F, 5'd0, rt, 16'h1234};   // LUI
    endcase
  endfunction

  // One cycle of stimulus plus the reference prediction for it
  task automatic step(input logic [1:0] sv, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] exc, input logic rdy, input logic fl_sba,
                      input logic fl_cp0);
    entry_t e;
    int     n;
    logic   any, two, adv, fl;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;
    e.inst   = {i1, i0};
    e.vaddr  = {$urandom, $urandom};
    e.hexc   = exc;
    e.ecode  = (2*EXC_W)'($urandom);
    e.refill = 2'($urandom);
    e.pdest  = {$urandom, $urandom};
    e.ptake  = 2'($urandom);
    e.ckpt   = (2*CKPT_W)'($urandom);
    e.isbr   = {m_br(i1), m_br(i0)};
    bus.IQ_supplyValid_i    = sv;
    bus.IQ_inst_p_i         = e.inst;
    bus.IQ_VAddr_p_i        = e.vaddr;
    bus.IQ_hasException_p_i = e.hexc;
    bus.IQ_ExcCode_p_i      = e.ecode;
    bus.IQ_isRefill_p_i     = e.refill;
    bus.IQ_predDest_p_i     = e.pdest;
    bus.IQ_predTake_p_i     = e.ptake;
    bus.IQ_checkPoint_p_i   = e.ckpt;
    bus.IS_ready_i          = rdy;
    bus.SBA_flush_w_i       = fl_sba;
    bus.CP0_excOccur_w_i    = fl_cp0;

    two = sv == 2'b11;
    any = two || sv == 2'b01;
    fl  = fl_sba || fl_cp0;
    adv = m_valid == 2'b00 || rdy;
    n   = 0;
    if (fl) m_wait = 1'b0;
    else if (adv) begin
      if (m_wait) begin
        if (any && exc[0]) begin n = 1; m_wait = 1'b0; end
        else if (two)      begin n = 2; m_wait = 1'b0; end
      end else if (any) begin
        if (m_br(i0)) begin
          if (two) n = 2; else m_wait = 1'b1;
        end else if (!two) n = 1;
        else n = m_single(i0, i1, exc) ? 1 : 2;
      end
    end
    e.valid = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
    mode_q.push_back(e.valid);
    if (n == 2) n_dual++;
    if (n == 1) n_single++;
    if (any && n == 0) n_stall++;

    if (fl) begin
      if (m_valid != 2'b00) exp_q.delete(0);
      m_valid = 2'b00;
    end else if (adv) begin
      m_valid = e.valid;
      if (n > 0) exp_q.push_back(e);
    end
  endtask

  // Monitor: per-cycle dequeue count, and the pair handed to IS on transfer
  always @(negedge clk) begin
    entry_t a;
    if (mon_on) begin
      if (mode_q.size() > 0) check("upDateMode", 256'(bus.ID_upDateMode_o), 256'(mode_q.pop_front()));
      if (bus.ID_valid_o != 2'b00 && bus.IS_ready_i &&
          !bus.SBA_flush_w_i && !bus.CP0_excOccur_w_i) begin
        a.valid  = bus.ID_valid_o;
        a.inst   = bus.ID_inst_p_o;
        a.vaddr  = bus.ID_VAddr_p_o;
        a.hexc   = bus.ID_hasException_p_o;
        a.ecode  = bus.ID_ExcCode_p_o;
        a.refill = bus.ID_isRefill_p_o;
        a.pdest  = bus.ID_predDest_p_o;
        a.ptake  = bus.ID_predTake_p_o;
        a.ckpt   = bus.ID_checkPoint_p_o;
        a.isbr   = bus.ID_isBranch_p_o;
        if (exp_q.size() == 0) check("unexpected_issue", 256'(a.valid), 256'(0));
        else                   check("issued_pair", 256'(a), 256'(exp_q.pop_front()));
      end
    end
  end

  localparam logic [31:0] ADDU_312 = 32'h0022_1821;  // ADDU $3,$1,$2
  localparam logic [31:0] ADDU_546 = 32'h0086_2821;  // ADDU $5,$4,$6
  localparam logic [31:0] SUBU_734 = 32'h0064_3823;  // SUBU $7,$3,$4
  localparam logic [31:0] BEQ_12   = 32'h1022_0004;  // BEQ $1,$2
  localparam logic [31:0] LW_21    = 32'h8C22_0010;  // LW $2,16($1)
  localparam logic [31:0] SW_43    = 32'hAC64_0010;  // SW $4,16($3)

  initial begin
    logic [1:0] sv;
    bus.IQ_supplyValid_i = 2'b00; bus.IQ_inst_p_i = '0; bus.IQ_VAddr_p_i = '0;
    bus.IQ_hasException_p_i = '0; bus.IQ_ExcCode_p_i = '0; bus.IQ_isRefill_p_i = '0;
    bus.IQ_predDest_p_i = '0; bus.IQ_predTake_p_i = '0; bus.IQ_checkPoint_p_i = '0;
    bus.IS_ready_i = 1'b1; bus.SBA_flush_w_i = 1'b0; bus.CP0_excOccur_w_i = 1'b0;

    // Reset state, with a supply present to show reset forces mode 00
    repeat (3) @(posedge clk);
    bus.IQ_supplyValid_i = 2'b11;
    @(negedge clk);
    check("reset_mode",   256'(bus.ID_upDateMode_o), 256'(0));
    check("reset_valid",  256'(bus.ID_valid_o), 256'(0));
    check("reset_isbr",   256'(bus.ID_isBranch_p_o), 256'(0));
    check("reset_payload", 256'({bus.ID_inst_p_o, bus.ID_VAddr_p_o, bus.ID_predDest_p_o,
                                 bus.ID_ExcCode_p_o, bus.ID_checkPoint_p_o}), 256'(0));

    // Directed scenarios
    step(2'b11, ADDU_312, ADDU_546, 2'b00, 1'b1, 1'b0, 1'b0);   // independent -> 11
    step(2'b11, ADDU_312, SUBU_734, 2'b00, 1'b1, 1'b0, 1'b0);   // RAW -> 01
    step(2'b11, SUBU_734, ADDU_546, 2'b00, 1'b1, 1'b0, 1'b0);   // -> 11
    repeat (3) step(2'b01, BEQ_12, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);  // wait DS
    step(2'b11, BEQ_12, ADDU_546, 2'b00, 1'b1, 1'b0, 1'b0);     // pair, isBranch 01
    step(2'b11, ADDU_312, ADDU_546, 2'b00, 1'b0, 1'b0, 1'b0);   // backpressure
    repeat (4) step(2'b11, ADDU_546, ADDU_312, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b11, ADDU_546, ADDU_312, 2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b01, BEQ_12, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);        // enter WAIT_DS
    step(2'b11, BEQ_12, ADDU_546, 2'b00, 1'b1, 1'b0, 1'b1);     // exception flush
    step(2'b01, ADDU_312, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);      // NORMAL -> 01
    step(2'b11, LW_21, SW_43, 2'b00, 1'b1, 1'b0, 1'b0);         // both mem -> 01
    step(2'b11, ADDU_312, ADDU_546, 2'b10, 1'b1, 1'b0, 1'b0);   // slot1 exc -> 01
    step(2'b01, ADDU_546, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0);      // faulting slot issues
    step(2'b10, ADDU_312, ADDU_546, 2'b00, 1'b1, 1'b0, 1'b0);   // 10 read as empty
    step(2'b01, BEQ_12, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0);        // faulting branch waits
    step(2'b11, BEQ_12, ADDU_546, 2'b01, 1'b1, 1'b0, 1'b0);     // exception wins -> 01

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 9))
        0:       sv = 2'b00;
        1:       sv = 2'b10;
        2, 3, 4: sv = 2'b01;
        default: sv = 2'b11;
      endcase
      step(sv, rand_inst(), rand_inst(),
           {$urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0},
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 24) == 0);
    end

    // Drain so every predicted pair must have been handed over
    repeat (4) step(2'b00, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("pending_pairs", 256'(exp_q.size()), 256'(0));
`ifdef ID_PAIR_PERF_EN
    check("dual_cnt",   256'(bus.ID_dualCnt_o),   256'(n_dual));
    check("single_cnt", 256'(bus.ID_singleCnt_o), 256'(n_single));
    check("stall_cnt",  256'(bus.ID_stallCnt_o),  256'(n_stall));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
